main_slave_driver: RTL and testbench
====================================

MAIN_SLAVE_DRIVER -- requirements
Module: main_slave_driver

Interface
REQ-001 SHALL have parameter RUN_TIMEOUT, default 200000000: max cycles to wait for done_port after start_port.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16: max cycles to wait for Sout_DataRdy[0] after a read or write strobe.
REQ-003 clock  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 cmd_valid  in  1  / cmd_ready  out  1  command handshake; transfer when both high on a rising edge.
REQ-006 cmd_op  in  2  00 = write, 01 = read, 10 = run, 11 = reserved.
REQ-007 cmd_addr  in  9  / cmd_wdata  in  64  / cmd_size  in  7  size in bits: legal values 8, 16, 32 and 64.
REQ-008 rsp_valid  out  1  / rsp_ready  in  1  response handshake; rsp_data  out  64;  rsp_err  out  1.
REQ-009 S_oe_ram  out  2  / S_we_ram  out  2  / S_addr_ram  out  18  / S_Wdata_ram  out  128  / S_data_ram_size  out  14  drive the accelerator slave port.
REQ-010 Sout_Rdata_ram  in  128  / Sout_DataRdy  in  2  slave-port return path.
REQ-011 start_port  out  1  / done_port  in  1  accelerator start/done.
REQ-012 cycle_count  out  32  cycles of the last run; busy  out  1  high whenever state is not IDLE.

Function
REQ-013 SHALL use only channel 0: bits [0], [8:0], [63:0], [6:0]; all channel-1 bits held 0 at all times.
REQ-014 SHALL implement the states IDLE, WSTB, RSTB, MWAIT, RUN, RWAIT, RSP.
REQ-015 cmd_ready = 1 only in IDLE; a command is accepted only in IDLE.
REQ-016 Write accept: IDLE->WSTB; SHALL hold S_we_ram[0]=1 with addr/data/size for exactly 1 cycle, then go to MWAIT.
REQ-017 Read accept: IDLE->RSTB; SHALL hold S_oe_ram[0]=1 with addr/size for exactly 1 cycle, then go to MWAIT.
REQ-018 MWAIT: Sout_DataRdy[0]=1 -> RSP; a read SHALL capture Sout_Rdata_ram[63:0] masked to cmd_size LSBs, a write SHALL report rsp_data=0; rsp_err=0.
REQ-019 MWAIT timeout: MEM_TIMEOUT cycles with no DataRdy -> RSP with rsp_err=1, rsp_data=0.
REQ-020 Illegal cmd_size or cmd_op=11 SHALL skip the slave port and go directly to RSP with rsp_err=1, rsp_data=0.
REQ-021 Run accept: IDLE->RUN; start_port=1 for exactly 1 cycle, then go to RWAIT; the cycle counter SHALL load 1 in the RUN cycle.
REQ-022 RWAIT: counter +1 per cycle; done_port=1 sampled -> latch the count into cycle_count (inclusive of the done cycle), RSP with rsp_data={32'd0,count}, rsp_err=0.
REQ-023 done_port=1 in the RUN cycle itself SHALL be ignored; only RWAIT samples done_port.
REQ-024 RWAIT timeout: the count reaches RUN_TIMEOUT -> RSP with rsp_err=1, cycle_count=RUN_TIMEOUT; the counter SHALL saturate, not wrap.
REQ-025 RSP: rsp_valid=1 with data/err stable until rsp_ready; then return to IDLE on the next cycle; no new command is accepted in that same cycle.
REQ-026 S_oe_ram/S_we_ram SHALL never be high together and never be high outside WSTB/RSTB; S_addr/Wdata/size SHALL be 0 when not strobing.

Reset
REQ-027 On reset assertion all state SHALL clear immediately: state=IDLE, cmd_ready=0 while reset is high, rsp_valid=0, start_port=0, all S_* outputs=0, rsp_data=0, rsp_err=0, cycle_count=0, busy=0.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no response; cmd_ready=1 from the first edge after deassertion.

Verification
REQ-029 Write addr=0x010, data=0x11223344, size=32, DataRdy on the 2nd cycle after the strobe -> 1-cycle S_we_ram=2'b01, S_addr_ram=18'h010, response err=0.
REQ-030 Read addr=0x010, size=8, Sout_Rdata_ram[63:0]=0xAABB -> rsp_data=0xBB, err=0.
REQ-031 Run, done_port rises 10 cycles after start_port -> cycle_count=11, rsp_data=11, start_port high exactly 1 cycle.
REQ-032 Read with DataRdy never asserted, MEM_TIMEOUT=16 -> rsp_err=1 after 16 MWAIT cycles; cmd_size=12 -> immediate err with no strobe.
REQ-033 rsp_ready held low for 5 cycles -> rsp_valid/data stable; cmd_valid asserted meanwhile is not accepted.
REQ-034 Reset asserted in RWAIT -> start_port=0, busy=0 asynchronously, no response; a following write completes normally.

Source files
------------

// File: rtl/main_slave_driver.sv
// Command-driven master for a single accelerator slave port: channel-0 memory
// writes and reads with a response timeout, plus start/done runs with a saturating cycle counter.
module main_slave_driver #(
    parameter int RUN_TIMEOUT = 200000000,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [8:0]   cmd_addr,
    input  logic [63:0]  cmd_wdata,
    input  logic [6:0]   cmd_size,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [63:0]  rsp_data,
    output logic         rsp_err,
    output logic [1:0]   S_oe_ram,
    output logic [1:0]   S_we_ram,
    output logic [17:0]  S_addr_ram,
    output logic [127:0] S_Wdata_ram,
    output logic [13:0]  S_data_ram_size,
    input  logic [127:0] Sout_Rdata_ram,
    input  logic [1:0]   Sout_DataRdy,
    output logic         start_port,
    input  logic         done_port,
    output logic [31:0]  cycle_count,
    output logic         busy
);

    localparam logic [1:0]  OP_WRITE = 2'b00;
    localparam logic [1:0]  OP_READ  = 2'b01;
    localparam logic [1:0]  OP_RUN   = 2'b10;
    localparam logic [31:0] RUN_TO   = 32'(RUN_TIMEOUT);
    localparam logic [31:0] MEM_LAST = 32'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WSTB, RSTB, MWAIT, RUN, RWAIT, RSP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [8:0]  r_addr;
    logic [63:0] r_wdata;
    logic [6:0]  r_size;
    logic        r_is_read;
    logic [31:0] r_mcnt;
    logic [31:0] r_cnt;
    logic [31:0] r_cycle_count;
    logic [63:0] r_rsp_data;
    logic        r_rsp_err;
    logic [31:0] w_cnt_inc;
    logic        w_cmd_legal;
    logic        w_wstb;
    logic        w_rstb;
    logic        w_stb;
    logic        w_unused;

    function automatic logic f_size_ok(input logic [6:0] s);
        return (s == 7'd8) || (s == 7'd16) || (s == 7'd32) || (s == 7'd64);
    endfunction

    function automatic logic [63:0] f_mask(input logic [63:0] d, input logic [6:0] s);
        case (s)
            7'd8:    return {56'd0, d[7:0]};
            7'd16:   return {48'd0, d[15:0]};
            7'd32:   return {32'd0, d[31:0]};
            default: return d;
        endcase
    endfunction

    assign w_cmd_legal = (cmd_op == OP_RUN) ||
                         (((cmd_op == OP_WRITE) || (cmd_op == OP_READ)) && f_size_ok(cmd_size));
    // Saturating so a long run can never wrap back below the timeout.
    assign w_cnt_inc   = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    if (!w_cmd_legal)           w_state_next = RSP;
                    else if (cmd_op == OP_WRITE) w_state_next = WSTB;
                    else if (cmd_op == OP_READ)  w_state_next = RSTB;
                    else                         w_state_next = RUN;
                end
            end
            WSTB, RSTB: w_state_next = MWAIT;
            MWAIT: begin
                if (Sout_DataRdy[0] || (r_mcnt == MEM_LAST)) w_state_next = RSP;
            end
            RUN:   w_state_next = RWAIT;
            RWAIT: begin
                if (done_port || (w_cnt_inc >= RUN_TO)) w_state_next = RSP;
            end
            RSP: begin
                if (rsp_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_size        <= '0;
            r_is_read     <= 1'b0;
            r_mcnt        <= '0;
            r_cnt         <= '0;
            r_cycle_count <= '0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_addr    <= cmd_addr;
                        r_wdata   <= cmd_wdata;
                        r_size    <= cmd_size;
                        r_is_read <= (cmd_op == OP_READ);
                        r_mcnt    <= '0;
                        r_cnt     <= 32'd1;
                        if (!w_cmd_legal) begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b1;
                        end
                    end
                end
                MWAIT: begin
                    if (Sout_DataRdy[0]) begin
                        r_rsp_data <= r_is_read ? f_mask(Sout_Rdata_ram[63:0], r_size) : 64'd0;
                        r_rsp_err  <= 1'b0;
                    end else if (r_mcnt == MEM_LAST) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end else begin
                        r_mcnt <= r_mcnt + 32'd1;
                    end
                end
                RWAIT: begin
                    // The count presented here includes the current cycle.
                    if (done_port) begin
                        r_cycle_count <= w_cnt_inc;
                        r_rsp_data    <= {32'd0, w_cnt_inc};
                        r_rsp_err     <= 1'b0;
                    end else if (w_cnt_inc >= RUN_TO) begin
                        r_cycle_count <= RUN_TO;
                        r_rsp_data    <= '0;
                        r_rsp_err     <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_wstb = (r_state == WSTB);
    assign w_rstb = (r_state == RSTB);
    assign w_stb  = w_wstb | w_rstb;

    assign cmd_ready       = (r_state == IDLE) && !reset;
    assign rsp_valid       = (r_state == RSP);
    assign rsp_data        = r_rsp_data;
    assign rsp_err         = r_rsp_err;
    assign start_port      = (r_state == RUN);
    assign busy            = (r_state != IDLE);
    assign cycle_count     = r_cycle_count;
    assign S_we_ram        = {1'b0, w_wstb};
    assign S_oe_ram        = {1'b0, w_rstb};
    assign S_addr_ram      = {9'd0, (w_stb ? r_addr : 9'd0)};
    assign S_Wdata_ram     = {64'd0, (w_wstb ? r_wdata : 64'd0)};
    assign S_data_ram_size = {7'd0, (w_stb ? r_size : 7'd0)};

    // Channel-1 return path is never used.
    assign w_unused = ^{Sout_Rdata_ram[127:64], Sout_DataRdy[1]};

endmodule

// File: tb/tb_main_slave_driver.sv
// Directed bench for main_slave_driver: memory write/read, timeouts, illegal commands,
// runs with done/timeout, response back-pressure and mid-run reset.
module tb_main_slave_driver;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [8:0]   cmd_addr = '0;
    logic [63:0]  cmd_wdata = '0;
    logic [6:0]   cmd_size = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [63:0]  rsp_data;
    logic         rsp_err;
    logic [1:0]   S_oe_ram;
    logic [1:0]   S_we_ram;
    logic [17:0]  S_addr_ram;
    logic [127:0] S_Wdata_ram;
    logic [13:0]  S_data_ram_size;
    logic [127:0] Sout_Rdata_ram = '0;
    logic [1:0]   Sout_DataRdy = 2'b00;
    logic         start_port;
    logic         done_port = 1'b0;
    logic [31:0]  cycle_count;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    main_slave_driver #(.RUN_TIMEOUT(40), .MEM_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
        .start_port(start_port), .done_port(done_port),
        .cycle_count(cycle_count), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [8:0] addr,
                             input logic [63:0] wdata, input logic [6:0] size);
        int budget = 50;
        while (!cmd_ready && budget > 0) begin
            tick();
            budget--;
        end
        n_checks++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b, required 1 within 50 cycles", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_size = size;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b required 0", cmd_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_checks++; if ({S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size} !== 36'd0) begin n_fail++; $display("FAIL rst_slave: oe=%b we=%b addr=%h size=%h required all 0", S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size); end
        n_checks++; if ({start_port, rsp_err, rsp_data, cycle_count} !== 98'd0) begin n_fail++; $display("FAIL rst_outputs: start=%b err=%b data=%h cc=%0d required 0", start_port, rsp_err, rsp_data, cycle_count); end
        reset = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b required 1", cmd_ready); end
    endtask

    task automatic test_write();
        issue_cmd(2'b00, 9'h010, 64'h11223344, 7'd32);
        n_checks++; if (S_we_ram !== 2'b01) begin n_fail++; $display("FAIL wr_we: got %b required 01", S_we_ram); end
        n_checks++; if (S_oe_ram !== 2'b00) begin n_fail++; $display("FAIL wr_oe: got %b required 00", S_oe_ram); end
        n_checks++; if (S_addr_ram !== 18'h010) begin n_fail++; $display("FAIL wr_addr: got %h required 010", S_addr_ram); end
        n_checks++; if (S_Wdata_ram !== 128'h11223344) begin n_fail++; $display("FAIL wr_wdata: got %h required 11223344", S_Wdata_ram); end
        n_checks++; if (S_data_ram_size !== 14'd32) begin n_fail++; $display("FAIL wr_size: got %0d required 32", S_data_ram_size); end
        tick();
        n_checks++; if ({S_we_ram, S_addr_ram, S_Wdata_ram} !== 148'd0) begin n_fail++; $display("FAIL wr_strobe_len: we=%b addr=%h required 0 after 1 cycle", S_we_ram, S_addr_ram); end
        tick();
        Sout_DataRdy = 2'b01;
        tick();
        Sout_DataRdy = 2'b00;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_valid: got %b required 1", rsp_valid); end
        n_checks++; if ({rsp_err, rsp_data} !== 65'd0) begin n_fail++; $display("FAIL wr_rsp: err=%b data=%h required err=0 data=0", rsp_err, rsp_data); end
        finish_rsp();
        n_checks++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL wr_return_idle: valid/busy/ready=%b required 001", {rsp_valid, busy, cmd_ready}); end
    endtask

    task automatic test_read();
        logic [6:0]  sizes [4] = '{7'd8, 7'd16, 7'd32, 7'd64};
        logic [63:0] exps  [4] = '{64'h11, 64'h2211, 64'h44332211, 64'h8877665544332211};
        Sout_Rdata_ram = {64'hFFFF_FFFF_FFFF_FFFF, 64'hAABB};
        issue_cmd(2'b01, 9'h010, 64'hFFFF, 7'd8);
        n_checks++; if ({S_oe_ram, S_we_ram} !== 4'b0100) begin n_fail++; $display("FAIL rd_strobe: oe=%b we=%b required oe=01 we=00", S_oe_ram, S_we_ram); end
        n_checks++; if ({S_addr_ram, S_data_ram_size, S_Wdata_ram} !== {18'h010, 14'd8, 128'd0}) begin n_fail++; $display("FAIL rd_fields: addr=%h size=%0d wdata=%h required 010/8/0", S_addr_ram, S_data_ram_size, S_Wdata_ram); end
        tick();
        Sout_DataRdy = 2'b01;
        tick();
        Sout_DataRdy = 2'b00;
        n_checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 64'hBB}) begin n_fail++; $display("FAIL rd_aabb: valid=%b err=%b data=%h required 1/0/bb", rsp_valid, rsp_err, rsp_data); end
        finish_rsp();
        Sout_Rdata_ram = {64'h0123_4567_89AB_CDEF, 64'h8877665544332211};
        for (int i = 0; i < 4; i++) begin
            issue_cmd(2'b01, 9'h1A0, 64'd0, sizes[i]);
            tick();
            Sout_DataRdy = 2'b01;
            tick();
            Sout_DataRdy = 2'b00;
            n_checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, exps[i]}) begin n_fail++; $display("FAIL rd_mask_%0d: valid=%b err=%b data=%h required 1/0/%h", sizes[i], rsp_valid, rsp_err, rsp_data, exps[i]); end
            finish_rsp();
        end
    endtask

    task automatic test_mem_timeout();
        issue_cmd(2'b01, 9'h020, 64'd0, 7'd32);
        tick();
        repeat (15) tick();
        n_checks++; if ({rsp_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL mto_early: valid=%b busy=%b required 0/1 at MWAIT cycle 16", rsp_valid, busy); end
        tick();
        n_checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 64'd0}) begin n_fail++; $display("FAIL mto_rsp: valid=%b err=%b data=%h required 1/1/0", rsp_valid, rsp_err, rsp_data); end
        finish_rsp();
    endtask

    task automatic test_illegal();
        logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b11, 2'b00};
        logic [6:0] szs [4] = '{7'd12, 7'd0, 7'd32, 7'd127};
        for (int i = 0; i < 4; i++) begin
            issue_cmd(ops[i], 9'h033, 64'h5555, szs[i]);
            n_checks++; if ({S_oe_ram, S_we_ram} !== 4'b0000) begin n_fail++; $display("FAIL ill_strobe_%0d: oe=%b we=%b required 0", i, S_oe_ram, S_we_ram); end
            n_checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 64'd0}) begin n_fail++; $display("FAIL ill_rsp_%0d: valid=%b err=%b data=%h required 1/1/0", i, rsp_valid, rsp_err, rsp_data); end
            finish_rsp();
        end
    endtask

    task automatic test_run();
        issue_cmd(2'b10, 9'd0, 64'd0, 7'd32);
        n_checks++; if ({start_port, busy} !== 2'b11) begin n_fail++; $display("FAIL run_start: start=%b busy=%b required 1/1", start_port, busy); end
        tick();
        n_checks++; if (start_port !== 1'b0) begin n_fail++; $display("FAIL run_start_len: got %b required 0 after 1 cycle", start_port); end
        repeat (9) tick();
        done_port = 1'b1;
        tick();
        done_port = 1'b0;
        n_checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 64'd11}) begin n_fail++; $display("FAIL run_rsp: valid=%b err=%b data=%0d required 1/0/11", rsp_valid, rsp_err, rsp_data); end
        n_checks++; if (cycle_count !== 32'd11) begin n_fail++; $display("FAIL run_cc: got %0d required 11", cycle_count); end
        finish_rsp();
        // done during the start cycle must not end the run
        issue_cmd(2'b10, 9'd0, 64'd0, 7'd32);
        done_port = 1'b1;
        tick();
        done_port = 1'b0;
        n_checks++; if ({rsp_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL run_early_done: valid=%b busy=%b required 0/1", rsp_valid, busy); end
        tick();
        tick();
        done_port = 1'b1;
        tick();
        done_port = 1'b0;
        n_checks++; if ({rsp_valid, cycle_count} !== {1'b1, 32'd4}) begin n_fail++; $display("FAIL run_cc4: valid=%b cc=%0d required 1/4", rsp_valid, cycle_count); end
        finish_rsp();
    endtask

    task automatic test_run_timeout();
        issue_cmd(2'b10, 9'd0, 64'd0, 7'd32);
        repeat (39) tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rto_early: got %b required 0 before count 40", rsp_valid); end
        tick();
        n_checks++; if ({rsp_valid, rsp_err, cycle_count} !== {2'b11, 32'd40}) begin n_fail++; $display("FAIL rto_rsp: valid=%b err=%b cc=%0d required 1/1/40", rsp_valid, rsp_err, cycle_count); end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        Sout_Rdata_ram = {64'd0, 64'h1234_CAFE};
        issue_cmd(2'b01, 9'h044, 64'd0, 7'd16);
        tick();
        Sout_DataRdy = 2'b01;
        tick();
        Sout_DataRdy = 2'b00;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 9'h055; cmd_wdata = 64'h99; cmd_size = 7'd8;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({rsp_valid, cmd_ready, rsp_err, rsp_data} !== {3'b100, 64'hCAFE}) begin n_fail++; $display("FAIL bp_hold_%0d: valid=%b ready=%b err=%b data=%h required 1/0/0/cafe", i, rsp_valid, cmd_ready, rsp_err, rsp_data); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        n_checks++; if ({busy, cmd_ready, S_we_ram} !== 4'b0100) begin n_fail++; $display("FAIL bp_no_accept: busy=%b ready=%b we=%b required 0/1/00", busy, cmd_ready, S_we_ram); end
    endtask

    task automatic test_reset_midrun();
        issue_cmd(2'b10, 9'd0, 64'd0, 7'd32);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if ({start_port, busy, rsp_valid, cmd_ready, cycle_count} !== 36'd0) begin n_fail++; $display("FAIL mr_async: start=%b busy=%b valid=%b ready=%b cc=%0d required all 0", start_port, busy, rsp_valid, cmd_ready, cycle_count); end
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mr_ready: got %b required 1", cmd_ready); end
        done_port = 1'b1;
        tick();
        done_port = 1'b0;
        tick();
        n_checks++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL mr_no_rsp: valid=%b busy=%b required 0/0", rsp_valid, busy); end
        issue_cmd(2'b00, 9'h1FF, 64'hDEADBEEF_01234567, 7'd64);
        n_checks++; if ({S_we_ram, S_addr_ram, S_Wdata_ram} !== {2'b01, 18'h1FF, 64'd0, 64'hDEADBEEF_01234567}) begin n_fail++; $display("FAIL mr_wr_strobe: we=%b addr=%h wdata=%h", S_we_ram, S_addr_ram, S_Wdata_ram); end
        tick();
        Sout_DataRdy = 2'b01;
        tick();
        Sout_DataRdy = 2'b00;
        n_checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 64'd0}) begin n_fail++; $display("FAIL mr_wr_rsp: valid=%b err=%b data=%h required 1/0/0", rsp_valid, rsp_err, rsp_data); end
        finish_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mem_timeout();
        test_illegal();
        test_run();
        test_run_timeout();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
